// File: rtl/pll_acq_ctrl.sv
// PLL acquisition controller: sweeps the fc multiplier, resets/settles/measures the PLL at each step, locks or fails.
// Latency: every output is registered; a start/stop pulse shows on the outputs one cycle after the edge that samples it.
// Backpressure: none; start is ignored while busy, stop always wins and returns the block to IDLE.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start, stop   one-cycle command pulses (stop has priority)
//   pd_in         signed phase-detector sample from the PLL, taken every cycle
//   fc            multiplier driven to the PLL
//   pll_rst       reset to the PLL, high in IDLE and PRST
//   busy          high while a sweep step is in progress (PRST, SETTLE, MEAS, EVAL)
//   locked, fail  state flags for LOCKED and FAIL
//   lost_lock     one-cycle pulse on leaving LOCKED because of a detected unlock
module pll_acq_ctrl #(
    parameter int FC_MIN        = 1,
    parameter int FC_MAX        = 10,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 20000,
    parameter int MEAS_CYCLES   = 10000,
    parameter int LOCK_THR      = 8,
    parameter int MISS_MAX      = 100,
    parameter int UNLOCK_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic signed [7:0] pd_in,
    output logic [7:0]        fc,
    output logic              pll_rst,
    output logic              busy,
    output logic              locked,
    output logic              fail,
    output logic              lost_lock
);

    // State encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRST   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_MEAS   = 3'd3;
    localparam logic [2:0] S_EVAL   = 3'd4;
    localparam logic [2:0] S_LOCKED = 3'd5;
    localparam logic [2:0] S_FAIL   = 3'd6;

    // Parameters folded to the register widths they are compared against.
    // The *_LAST values are terminal counts of a counter that starts at 0.
    localparam logic [7:0]  FC_MIN_L    = 8'(FC_MIN);
    localparam logic [7:0]  FC_MAX_L    = 8'(FC_MAX);
    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] MEAS_LAST   = 16'(MEAS_CYCLES - 1);
    localparam logic [15:0] UNLOCK_LAST = 16'(UNLOCK_CYCLES - 1);
    localparam logic [15:0] LOCK_THR_L  = 16'(LOCK_THR);
    localparam logic [15:0] MISS_MAX_L  = 16'(MISS_MAX);
    localparam logic [15:0] CNT_SAT     = 16'hFFFF;

    // Registers
    logic [2:0]  state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;       // cycle counter for PRST/SETTLE/MEAS
    logic [15:0] miss_q,      miss_d;      // out-of-lock samples in the current window
    logic [15:0] unlock_q,    unlock_d;    // consecutive out-of-lock samples in LOCKED
    logic [7:0]  fc_q,        fc_d;
    logic        pll_rst_q,   pll_rst_d;
    logic        busy_q,      busy_d;
    logic        locked_q,    locked_d;
    logic        fail_q,      fail_d;
    logic        lost_lock_q, lost_lock_d;

    // Phase-detector magnitude
    // Two's complement negation of -128 would overflow back to -128, so that
    // one code is clamped to 127 instead.
    logic [7:0] pd_raw;
    logic [7:0] pd_abs;
    logic       pd_out;    // sample is outside the lock window

    assign pd_raw = pd_in;

    always_comb begin
        pd_abs = pd_raw;
        if (pd_raw == 8'h80) begin
            pd_abs = 8'd127;
        end else if (pd_raw[7]) begin
            pd_abs = ~pd_raw + 8'd1;
        end
    end

    assign pd_out = ({8'd0, pd_abs} > LOCK_THR_L);

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_d      = miss_q;
        unlock_d    = unlock_q;
        fc_d        = fc_q;
        lost_lock_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRST;
                    cnt_d   = '0;
                    fc_d    = FC_MIN_L;
                end
            end

            S_PRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_SETTLE: begin
                // pd_in is not looked at here: the loop is still pulling in.
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_MEAS;
                    cnt_d   = '0;
                    miss_d  = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_MEAS: begin
                if (pd_out && (miss_q != CNT_SAT)) begin
                    miss_d = miss_q + 16'd1;
                end
                if (cnt_q == MEAS_LAST) begin
                    state_d = S_EVAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_EVAL: begin
                if (miss_q <= MISS_MAX_L) begin
                    state_d  = S_LOCKED;
                    unlock_d = '0;
                end else if (fc_q < FC_MAX_L) begin
                    // Only step while below the top of the range, so fc
                    // can never pass FC_MAX or wrap.
                    state_d = S_PRST;
                    cnt_d   = '0;
                    fc_d    = fc_q + 8'd1;
                end else begin
                    state_d = S_FAIL;
                    fc_d    = FC_MAX_L;
                end
            end

            S_LOCKED: begin
                if (start) begin
                    state_d  = S_PRST;
                    cnt_d    = '0;
                    unlock_d = '0;
                    fc_d     = FC_MIN_L;
                end else if (pd_out) begin
                    if (unlock_q >= UNLOCK_LAST) begin
                        // This sample brings the run to UNLOCK_CYCLES:
                        // declare loss of lock and resweep from the bottom.
                        state_d     = S_PRST;
                        cnt_d       = '0;
                        unlock_d    = '0;
                        fc_d        = FC_MIN_L;
                        lost_lock_d = 1'b1;
                    end else begin
                        unlock_d = unlock_q + 16'd1;
                    end
                end else begin
                    unlock_d = '0;
                end
            end

            S_FAIL: begin
                if (start) begin
                    state_d = S_PRST;
                    cnt_d   = '0;
                    fc_d    = FC_MIN_L;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                miss_d  = '0;
                unlock_d = '0;
                fc_d    = FC_MIN_L;
            end
        endcase

        // stop overrides everything above, including a simultaneous start.
        // fc returns to FC_MIN, the same value IDLE has after rst; the PLL
        // is held in reset there, so the change is harmless.
        if (stop) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            miss_d      = '0;
            unlock_d    = '0;
            fc_d        = FC_MIN_L;
            lost_lock_d = 1'b0;
        end
    end

    // Flags are decoded from the next state so the registered outputs line up
    // with the registered state.
    always_comb begin
        pll_rst_d = (state_d == S_IDLE) || (state_d == S_PRST);
        busy_d    = (state_d == S_PRST) || (state_d == S_SETTLE) ||
                    (state_d == S_MEAS) || (state_d == S_EVAL);
        locked_d  = (state_d == S_LOCKED);
        fail_d    = (state_d == S_FAIL);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            miss_q      <= '0;
            unlock_q    <= '0;
            fc_q        <= FC_MIN_L;
            pll_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            miss_q      <= miss_d;
            unlock_q    <= unlock_d;
            fc_q        <= fc_d;
            pll_rst_q   <= pll_rst_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            lost_lock_q <= lost_lock_d;
        end
    end

    assign fc        = fc_q;
    assign pll_rst   = pll_rst_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign fail      = fail_q;
    assign lost_lock = lost_lock_q;

endmodule

// File: doc/pll_acq_ctrl.md
PLL_ACQ_CTRL -- requirements
Module: pll_acq_ctrl

Interface
REQ-001 Parameter FC_MIN, default 1: first fc multiplier tried in a sweep.
REQ-002 Parameter FC_MAX, default 10: last fc multiplier tried; FC_MIN <= FC_MAX <= 255.
REQ-003 Parameter RST_CYCLES, default 4: cycles pll_rst is held high per step.
REQ-004 Parameter SETTLE_CYCLES, default 20000: cycles ignored after pll_rst falls.
REQ-005 Parameter MEAS_CYCLES, default 10000: measurement window length, in cycles.
REQ-006 Parameter LOCK_THR, default 8: |pd_in| <= LOCK_THR counts as an in-lock sample.
REQ-007 Parameter MISS_MAX, default 100: maximum out-of-lock samples allowed in a window that still passes.
REQ-008 Parameter UNLOCK_CYCLES, default 2000: consecutive out-of-lock samples in LOCKED that declare loss of lock.
REQ-009 Constraint: all cycle-count parameters are 1..65535; counters are 16 bits.
REQ-010 clk  input  1  system clock; all logic on rising edge.
REQ-011 rst  input  1  synchronous, active-high reset.
REQ-012 start  input  1  one-cycle pulse; begins a sweep from IDLE, FAIL or LOCKED.
REQ-013 stop  input  1  one-cycle pulse; aborts to IDLE from any state.
REQ-014 pd_in  input  8 signed  phase-detector output of the PLL.
REQ-015 fc  output  8  multiplier driven to the PLL.
REQ-016 pll_rst  output  1  reset to the PLL (active high).
REQ-017 busy  output  1  high in PRST, SETTLE, MEAS and EVAL.
REQ-018 locked  output  1  high only in LOCKED.
REQ-019 fail  output  1  high only in FAIL.
REQ-020 lost_lock  output  1  one-cycle pulse when LOCKED exits on a detected unlock.

Function
REQ-021 FSM states SHALL be IDLE, PRST, SETTLE, MEAS, EVAL, LOCKED and FAIL; all outputs SHALL be registered.
REQ-022 IDLE: on start -> fc=FC_MIN and go to PRST.
REQ-023 PRST: pll_rst=1 for exactly RST_CYCLES cycles, then go to SETTLE with pll_rst=0.
REQ-024 SETTLE: count SETTLE_CYCLES cycles, then go to MEAS with the miss counter cleared.
REQ-025 MEAS: for MEAS_CYCLES cycles, increment the miss counter when |pd_in| > LOCK_THR; the miss counter SHALL saturate at 65535.
REQ-026 |pd_in| SHALL be computed saturating: -128 maps to 127.
REQ-027 EVAL, one cycle: misses <= MISS_MAX -> LOCKED; otherwise, if fc < FC_MAX, fc = fc+1 and go to PRST; otherwise go to FAIL.
REQ-028 LOCKED: fc held; the unlock counter increments on each sample with |pd_in| > LOCK_THR and clears on each in-lock sample.
REQ-029 LOCKED exit: when the unlock counter reaches UNLOCK_CYCLES, pulse lost_lock, set fc=FC_MIN and go to PRST (automatic resweep).
REQ-030 FAIL: fc holds FC_MAX and pll_rst=0; wait for start.
REQ-031 start in LOCKED or FAIL SHALL restart the sweep at FC_MIN; start in a busy state SHALL be ignored.
REQ-032 stop in any state SHALL go to IDLE next cycle with pll_rst=1 and all flags low.
REQ-033 start and stop in the same cycle: stop wins.
REQ-034 fc SHALL change only on the transitions into PRST and SHALL remain stable while pll_rst=0.
REQ-035 fc SHALL never exceed FC_MAX; no wrap-around is permitted.

Reset
REQ-036 rst SHALL force IDLE, fc=FC_MIN, pll_rst=1, busy=0, locked=0, fail=0, lost_lock=0 and clear all counters, including mid-sweep.
REQ-037 The first cycle after rst falls SHALL be IDLE, and start SHALL be accepted in that cycle.

Verification
Bench uses RST_CYCLES=2, SETTLE_CYCLES=5, MEAS_CYCLES=10, MISS_MAX=2, UNLOCK_CYCLES=3, FC_MIN=1, FC_MAX=3.
REQ-038 pd_in=0 constantly, start pulse -> pll_rst high 2 cycles, locked=1 exactly 2+5+10+1 cycles after PRST entry, fc=1.
REQ-039 pd_in=50 while fc<3, pd_in=0 at fc=3 -> fc steps 1,2,3 -> locked=1 with fc=3.
REQ-040 pd_in=-128 throughout -> sweep 1..3 -> fail=1, fc=3; then start -> fc=1, busy=1.
REQ-041 In LOCKED, pd_in=20 for 2 cycles, then 0, then 20 for 3 cycles -> no unlock after the first burst; lost_lock pulse on the 3rd cycle of the second burst, then PRST with fc=1.
REQ-042 MEAS window with exactly 2 misses passes; a window with 3 misses advances fc.
REQ-043 Assert rst in MEAS at fc=2, and separately pulse start and stop together in LOCKED -> both cases reach IDLE, fc=1, pll_rst=1, all flags 0.
